// File: rtl/obi_pkg.sv
// rtl/obi_pkg.sv - shared integrity code, widths and response type for the data bus responder
//
// Contents:
//   INTG_W        width of the bus integrity field
//   obi_resp_t    response pipe entry {valid, err, rdata}
//   obi_intg_enc  39/32 Hsiao SECDED check bits, inverted form, same code as the core LSU
package obi_pkg;

   localparam int INTG_W = 7;

   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] rdata;
   } obi_resp_t;

   // The final XOR with 7'h2A is the "inverted" variant: all-zero data does not
   // produce an all-zero check field, so a stuck-at-0 bus is detectable.
   function automatic logic [INTG_W-1:0] obi_intg_enc(input logic [31:0] data);
      logic [INTG_W-1:0] chk;
      chk[0] = ^(data & 32'h2606BD25);
      chk[1] = ^(data & 32'hDEBA8050);
      chk[2] = ^(data & 32'h413D89AA);
      chk[3] = ^(data & 32'h31234ED1);
      chk[4] = ^(data & 32'hC2C1323B);
      chk[5] = ^(data & 32'h2DCC624C);
      chk[6] = ^(data & 32'h98505586);
      return chk ^ 7'h2A;
   endfunction

endpackage

// File: rtl/obi_resp_pipe.sv
// rtl/obi_resp_pipe.sv - fixed-latency shift register of bus responses
//
// Ports:
//   clk       clock
//   clr       synchronous active-high clear; drops every in-flight response
//   in_resp   response entering the pipe this cycle (valid=0 for a bubble)
//   out_resp  response leaving the pipe, DEPTH cycles after entry
module obi_resp_pipe
   import obi_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic      clk,
   input  logic      clr,
   input  obi_resp_t in_resp,
   output obi_resp_t out_resp
);

   obi_resp_t stage_q [DEPTH];

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= in_resp;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign out_resp = stage_q[DEPTH-1];

endmodule

// File: rtl/obi_data_mem_responder.sv
// rtl/obi_data_mem_responder.sv - req/gnt/rvalid data memory responder with integrity
//
// Ports:
//   CLK, RST            clock; synchronous active-high reset
//   data_req_i          request from the initiator
//   data_gnt_o          request accepted this cycle (combinational)
//   data_we_i           1 = write, 0 = read
//   data_be_i           byte enables (writes only)
//   data_addr_i         byte address, bits [1:0] ignored
//   data_wdata_i        write data
//   data_wdata_intg_i   integrity of data_wdata_i
//   data_rvalid_o       response valid, RVALID_LAT cycles after the grant
//   data_rdata_o        read data, 0 for writes and errors
//   data_rdata_intg_o   integrity of data_rdata_o, every cycle
//   data_err_o          response error, qualified by data_rvalid_o
module obi_data_mem_responder
   import obi_pkg::*;
#(
   parameter int          DEPTH_WORDS     = 1024,
   parameter logic [31:0] BASE_ADDR       = 32'h0000_2000,
   parameter int          GNT_STALL       = 0,
   parameter int          RVALID_LAT      = 1,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              data_req_i,
   output logic              data_gnt_o,
   input  logic              data_we_i,
   input  logic [3:0]        data_be_i,
   input  logic [31:0]       data_addr_i,
   input  logic [31:0]       data_wdata_i,
   input  logic [INTG_W-1:0] data_wdata_intg_i,
   output logic              data_rvalid_o,
   output logic [31:0]       data_rdata_o,
   output logic [INTG_W-1:0] data_rdata_intg_o,
   output logic              data_err_o
);

   localparam int          IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  MAX_OUT   = 4'(MAX_OUTSTANDING);
   localparam logic [3:0]  STALL_MAX = 4'(GNT_STALL);
   localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

   logic [31:0]      mem [DEPTH_WORDS];
   logic [3:0]       out_q, out_d, out_busy;
   logic [3:0]       stall_q, stall_d;
   logic [29:0]      word_off;
   logic [IDX_W-1:0] idx;
   logic             in_range, intg_ok, accept;
   logic             unused_addr_lsb;
   obi_resp_t        resp_in, resp_out;

   assign unused_addr_lsb = ^data_addr_i[1:0];

   assign word_off = data_addr_i[31:2] - BASE_ADDR[31:2];
   assign in_range = (data_addr_i >= BASE_ADDR) && (word_off < DEPTH_LIM);
   assign idx      = word_off[IDX_W-1:0];
   assign intg_ok  = (data_wdata_intg_i == obi_intg_enc(data_wdata_i));

   // A response leaving the pipe this cycle frees its slot immediately, so a
   // full responder can grant again in the same cycle its oldest rvalid is shown.
   assign out_busy   = out_q - {3'b000, data_rvalid_o};
   assign data_gnt_o = data_req_i & ~RST & (out_busy < MAX_OUT) & (stall_q == STALL_MAX);
   assign accept     = data_req_i & data_gnt_o;

   always_comb begin
      resp_in = '0;
      if (accept) begin
         resp_in.valid = 1'b1;
         if (!in_range || (data_we_i && !intg_ok)) begin
            resp_in.err = 1'b1;
         end else if (!data_we_i) begin
            resp_in.rdata = mem[idx];
         end
      end
   end

   // Array is deliberately not reset.
   always_ff @(posedge CLK) begin
      if (accept && data_we_i && in_range && intg_ok) begin
         for (int b = 0; b < 4; b++) begin
            if (data_be_i[b]) begin
               mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      out_d = out_q;
      if (accept && !data_rvalid_o) begin
         out_d = out_q + 4'd1;
      end else if (!accept && data_rvalid_o) begin
         out_d = out_q - 4'd1;
      end
      stall_d = stall_q;
      if (!data_req_i || data_gnt_o) begin
         stall_d = '0;
      end else if (stall_q != STALL_MAX) begin
         stall_d = stall_q + 4'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         out_q   <= '0;
         stall_q <= '0;
      end else begin
         out_q   <= out_d;
         stall_q <= stall_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         assert (out_d <= MAX_OUT);
         assert (!(data_rvalid_o && (out_q == 4'd0)));
      end
   end

   obi_resp_pipe #(
      .DEPTH (RVALID_LAT)
   ) u_resp_pipe (
      .clk      (CLK),
      .clr      (RST),
      .in_resp  (resp_in),
      .out_resp (resp_out)
   );

   assign data_rvalid_o     = resp_out.valid;
   assign data_err_o        = resp_out.err;
   assign data_rdata_o      = resp_out.rdata;
   assign data_rdata_intg_o = obi_intg_enc(resp_out.rdata);

endmodule

// File: tb/tb_obi_data_mem_responder.sv
// tb/tb_obi_data_mem_responder.sv - directed self-checking bench for obi_data_mem_responder
//
// Four responders share one clock:
//   0: defaults (GNT_STALL=0, RVALID_LAT=1, MAX_OUTSTANDING=2)
//   1: RVALID_LAT=3, MAX_OUTSTANDING=2 (throughput / backpressure)
//   2: GNT_STALL=3 (grant stall)
//   3: RVALID_LAT=2 (reset mid-operation)
module tb_obi_data_mem_responder;

   localparam logic [31:0] MASKS [7] = '{32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
                                         32'hC2C1323B, 32'h2DCC624C, 32'h98505586};

   logic        clk;
   logic        rst    [4];
   logic        req    [4];
   logic        gnt    [4];
   logic        we     [4];
   logic [3:0]  be     [4];
   logic [31:0] addr   [4];
   logic [31:0] wdata  [4];
   logic [6:0]  wintg  [4];
   logic        rvalid [4];
   logic [31:0] rdata  [4];
   logic [6:0]  rintg  [4];
   logic        err    [4];

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] s_gpat;
   int          s_max, s_nrv, s_first;
   logic [31:0] rv_data [16];

   for (genvar g = 0; g < 4; g++) begin : g_dut
      obi_data_mem_responder #(
         .DEPTH_WORDS     (1024),
         .BASE_ADDR       (32'h0000_2000),
         .GNT_STALL       ((g == 2) ? 3 : 0),
         .RVALID_LAT      ((g == 1) ? 3 : ((g == 3) ? 2 : 1)),
         .MAX_OUTSTANDING (2)
      ) u_dut (
         .CLK               (clk),
         .RST               (rst[g]),
         .data_req_i        (req[g]),
         .data_gnt_o        (gnt[g]),
         .data_we_i         (we[g]),
         .data_be_i         (be[g]),
         .data_addr_i       (addr[g]),
         .data_wdata_i      (wdata[g]),
         .data_wdata_intg_i (wintg[g]),
         .data_rvalid_o     (rvalid[g]),
         .data_rdata_o      (rdata[g]),
         .data_rdata_intg_o (rintg[g]),
         .data_err_o        (err[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [6:0] ref_intg(input logic [31:0] d);
      logic [6:0] p;
      for (int i = 0; i < 7; i++) begin
         p[i] = ^(d & MASKS[i]);
      end
      return p ^ 7'b0101010;
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // One isolated transaction: latencies are in cycles (grant relative to
   // request start, rvalid relative to the grant cycle); -1 means never seen.
   task automatic xact(input int u, input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d, input logic [6:0] ig, output int g_lat,
                       output int r_lat, output logic e, output logic [31:0] rd,
                       output logic [6:0] ri);
      g_lat = -1; r_lat = -1; e = 1'b0; rd = '0; ri = '0;
      @(posedge clk); #1;
      req[u] = 1'b1; we[u] = w; be[u] = b; addr[u] = a; wdata[u] = d; wintg[u] = ig;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (gnt[u]) begin
            g_lat = c;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      req[u] = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (rvalid[u]) begin
            r_lat = c; e = err[u]; rd = rdata[u]; ri = rintg[u];
            break;
         end
      end
   endtask

   task automatic xchk(input string tag, input int u, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d, input logic [6:0] ig,
                       input int eg, input int er, input logic ee, input logic [31:0] ed);
      int g_lat, r_lat;
      logic e;
      logic [31:0] rd;
      logic [6:0] ri;
      xact(u, w, b, a, d, ig, g_lat, r_lat, e, rd, ri);
      check({tag, ".gnt_lat"}, g_lat, eg);
      check({tag, ".rv_lat"}, r_lat, er);
      check({tag, ".err"}, e, ee);
      check({tag, ".rdata"}, rd, ed);
      check({tag, ".rintg"}, ri, ref_intg(ed));
   endtask

   // req held high for n transactions to consecutive words; records the grant
   // pattern per cycle, peak outstanding, and the rvalid data in arrival order.
   task automatic stream(input int u, input logic w, input int n);
      int gi, outc;
      logic g;
      gi = 0; outc = 0; s_max = 0; s_nrv = 0; s_first = -1; s_gpat = '0;
      @(posedge clk); #1;
      req[u] = 1'b1; we[u] = w; be[u] = 4'hF;
      addr[u] = 32'h2000; wdata[u] = 32'hA000_0000; wintg[u] = ref_intg(32'hA000_0000);
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         g = gnt[u];
         if (c < 16) s_gpat[c] = g;
         if (rvalid[u]) begin
            if (s_first < 0) s_first = c;
            if (s_nrv < 16) rv_data[s_nrv] = rdata[u];
            s_nrv++;
         end
         outc = outc + int'(g) - int'(rvalid[u]);
         if (outc > s_max) s_max = outc;
         @(posedge clk); #1;
         if (g) begin
            gi++;
            if (gi == n) begin
               req[u] = 1'b0;
            end else begin
               addr[u]  = 32'h2000 + 32'(4 * gi);
               wdata[u] = 32'hA000_0000 + 32'(gi);
               wintg[u] = ref_intg(wdata[u]);
            end
         end
      end
   endtask

   initial begin
      int first;
      logic seen;
      for (int u = 0; u < 4; u++) begin
         rst[u] = 1'b1; req[u] = 1'b0; we[u] = 1'b0; be[u] = '0;
         addr[u] = '0; wdata[u] = '0; wintg[u] = '0;
      end

      // reset state and grant suppression while RST is high
      @(posedge clk); #1;
      req[0] = 1'b1;
      @(negedge clk);
      check("rst.gnt_blocked", gnt[0], 0);
      req[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int u = 0; u < 4; u++) rst[u] = 1'b0;
      @(negedge clk);
      check("rst.gnt", gnt[0], 0);
      check("rst.rvalid", rvalid[0], 0);
      check("rst.err", err[0], 0);
      check("rst.rdata", rdata[0], 0);
      check("rst.rintg", rintg[0], 32'h2A);

      // single write / read, byte enables, error paths
      xchk("wr1", 0, 1, 4'hF, 32'h2004, 32'hDEADBEEF, ref_intg(32'hDEADBEEF), 0, 1, 0, 0);
      xchk("rd1", 0, 0, 4'hF, 32'h2004, 32'h0, 7'h0, 0, 1, 0, 32'hDEADBEEF);
      xchk("pre", 0, 1, 4'hF, 32'h2008, 32'h11223344, ref_intg(32'h11223344), 0, 1, 0, 0);
      xchk("be", 0, 1, 4'b0101, 32'h2008, 32'hAABBCCDD, ref_intg(32'hAABBCCDD), 0, 1, 0, 0);
      xchk("rdbe", 0, 0, 4'h0, 32'h2008, 32'h0, 7'h0, 0, 1, 0, 32'h11BB33DD);
      xchk("lo", 0, 0, 4'hF, 32'h1FFC, 32'h0, 7'h0, 0, 1, 1, 0);
      xchk("hi", 0, 0, 4'hF, 32'h3000, 32'h0, 7'h0, 0, 1, 1, 0);
      xchk("lastwr", 0, 1, 4'hF, 32'h2FFC, 32'h0BADCAFE, ref_intg(32'h0BADCAFE), 0, 1, 0, 0);
      xchk("lastrd", 0, 0, 4'hF, 32'h2FFE, 32'h0, 7'h0, 0, 1, 0, 32'h0BADCAFE);
      xchk("badintg", 0, 1, 4'hF, 32'h2008, 32'h55555555, ref_intg(32'h55555555) ^ 7'h01, 0, 1, 1, 0);
      xchk("keep", 0, 0, 4'hF, 32'h2008, 32'h0, 7'h0, 0, 1, 0, 32'h11BB33DD);

      // write then read of the same word on consecutive cycles
      @(posedge clk); #1;
      req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h200C;
      wdata[0] = 32'h600DF00D; wintg[0] = ref_intg(32'h600DF00D);
      @(negedge clk);
      check("b2b.wgnt", gnt[0], 1);
      @(posedge clk); #1;
      we[0] = 1'b0;
      @(negedge clk);
      check("b2b.rgnt", gnt[0], 1);
      check("b2b.wrv", rvalid[0], 1);
      check("b2b.werr", err[0], 0);
      @(posedge clk); #1;
      req[0] = 1'b0;
      @(negedge clk);
      check("b2b.rrv", rvalid[0], 1);
      check("b2b.rdata", rdata[0], 32'h600DF00D);

      // throughput with RVALID_LAT=3, MAX_OUTSTANDING=2
      stream(1, 1'b1, 6);
      check("tp.wr_gpat", s_gpat, 16'h00DB);
      check("tp.wr_max", s_max, 2);
      check("tp.wr_nrv", s_nrv, 6);
      check("tp.wr_first", s_first, 3);
      stream(1, 1'b0, 6);
      check("tp.rd_gpat", s_gpat, 16'h00DB);
      check("tp.rd_max", s_max, 2);
      check("tp.rd_nrv", s_nrv, 6);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("tp.rd_data%0d", k), rv_data[k], 32'hA000_0000 + 32'(k));
      end

      // grant stall of 3 cycles
      first = -1;
      @(posedge clk); #1;
      req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (gnt[2]) begin
            first = c;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      req[2] = 1'b0;
      check("stall.first", first, 3);
      repeat (3) @(posedge clk);
      #1;
      first = -1;
      for (int c = 0; c < 16; c++) begin
         req[2] = (c < 2) || (c >= 4);
         @(negedge clk);
         if (gnt[2]) begin
            first = c;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      req[2] = 1'b0;
      check("stall.redo", first, 7);

      // reset one cycle after a read grant, RVALID_LAT=2
      xchk("r3wr", 3, 1, 4'hF, 32'h2010, 32'hCAFEF00D, ref_intg(32'hCAFEF00D), 0, 2, 0, 0);
      @(posedge clk); #1;
      req[3] = 1'b1; we[3] = 1'b0; addr[3] = 32'h2010;
      @(negedge clk);
      check("r3.gnt", gnt[3], 1);
      @(posedge clk); #1;
      req[3] = 1'b0; rst[3] = 1'b1;
      @(negedge clk);
      seen = rvalid[3];
      @(posedge clk); #1;
      rst[3] = 1'b0;
      @(negedge clk);
      check("r3.rvalid", rvalid[3], 0);
      check("r3.err", err[3], 0);
      check("r3.rdata", rdata[3], 0);
      check("r3.rintg", rintg[3], 32'h2A);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         seen = seen | rvalid[3];
      end
      check("r3.no_rvalid", seen, 0);
      xchk("r3rd", 3, 0, 4'hF, 32'h2010, 32'h0, 7'h0, 0, 2, 0, 32'hCAFEF00D);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/obi_data_mem_responder.md
Name: obi_data_mem_responder

Overview:
- Memory-side responder for the core's req/gnt/rvalid data bus, i.e. the slave end of the LSU interface.
- Serves reads and byte-enabled writes from an internal word array.
- Has programmable grant stall and response latency, tracks outstanding transactions, and generates and checks 7-bit bus integrity.
- Used as the data memory in core-level simulation and FPGA builds.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array.
- BASE_ADDR, 32'h0000_2000: byte address of word 0.
- GNT_STALL, 0: cycles gnt is withheld after a request is first presented (0..15).
- RVALID_LAT, 1: cycles from the grant cycle to rvalid (1..4).
- MAX_OUTSTANDING, 2: granted-but-unanswered transactions allowed (1..RVALID_LAT+1).

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  synchronous reset, active high.
- data_req_i  in  1  request from initiator.
- data_gnt_o  out  1  request accepted this cycle.
- data_we_i  in  1  1=write, 0=read.
- data_be_i  in  4  byte enables.
- data_addr_i  in  32  byte address; bits [1:0] ignored.
- data_wdata_i  in  32  write data.
- data_wdata_intg_i  in  7  integrity of data_wdata_i.
- data_rvalid_o  out  1  response valid.
- data_rdata_o  out  32  read data (0 for writes and errors).
- data_rdata_intg_o  out  7  integrity of data_rdata_o.
- data_err_o  out  1  response error, qualified by rvalid.

Interface rule: one clock; reset is synchronous and active-high (CLK, RST).

Behaviour:
- Reset (RST high at a rising edge):
  - rvalid, err, rdata and gnt are 0; rdata_intg is the encoding of 0.
  - Outstanding count, stall counter and response pipe are cleared. In-flight responses are dropped, never delivered.
  - Array contents are not reset.
- Grant (combinational):
  - gnt = req & ~RST & (outstanding < MAX_OUTSTANDING) & (stall_cnt == GNT_STALL).
  - stall_cnt counts up while req=1 and gnt=0, saturating at GNT_STALL. It clears on gnt or when req drops.
  - With GNT_STALL=0, gnt is asserted in the same cycle as req.
- Accept (rising edge with req&gnt):
  - Word index idx = (addr - BASE_ADDR) >> 2.
  - Out of range (addr < BASE_ADDR or idx >= DEPTH_WORDS): err=1, no array access.
  - Write with integrity mismatch (data_wdata_intg_i != encode(wdata)): err=1, no array write.
  - Valid write: bytes with be[i]=1 take wdata[8i+7:8i]; all other bytes unchanged. Response rdata=0, err=0.
  - Valid read: captures the full word of the array as it was before any write at that same edge. be is ignored for reads.
- Response pipe:
  - Shift register of depth RVALID_LAT carrying {valid, err, rdata}.
  - rvalid is asserted exactly RVALID_LAT cycles after the grant edge, for 1 cycle per transaction, in strict acceptance order.
  - Back-to-back grants produce back-to-back rvalids.
  - rdata_intg = encode(rdata_o) in every cycle, including when rvalid=0.
- Outstanding count:
  - +1 on grant, -1 on rvalid; a grant and an rvalid in the same cycle leave it unchanged.
  - Never exceeds MAX_OUTSTANDING; overflow or underflow is an assertion failure.
- Ordering: a read granted the cycle after a write to the same word returns the written data.
- Protocol violation: the responder does not check for address or data changing while req=1 and gnt=0; the latest values are used at grant.

Decomposition:
- Shared package obi_pkg holds:
  - the 39/32 Hsiao SECDED inverted encode function (the same code used by the core LSU);
  - the constant INTG_W=7;
  - the response struct {valid, err, rdata}.
- One sub-module, obi_resp_pipe: parameterised shift register of response structs with synchronous active-high clear.

Test Plan:
- Single write then read, defaults:
  - Write addr 0x2004, be=4'hF, wdata=0xDEADBEEF with correct intg: gnt in the same cycle, rvalid 1 cycle later with err=0.
  - Read 0x2004: rvalid 1 cycle after its grant, rdata=0xDEADBEEF, rdata_intg=encode(0xDEADBEEF).
- Byte enables:
  - Preload 0x11223344; write be=4'b0101 with data 0xAABBCCDD.
  - Read returns 0x11BB33DD.
- Error paths:
  - Read 0x1FFC: rvalid with err=1, rdata=0.
  - Read BASE_ADDR+4*DEPTH_WORDS: rvalid with err=1, rdata=0.
  - Write with intg XOR 7'h01: err=1, and a subsequent read shows the word unchanged.
- Throughput and backpressure:
  - Setup: RVALID_LAT=3, MAX_OUTSTANDING=2; req held high for 6 reads.
  - Expect the pattern gnt,gnt,0,gnt,gnt,0…; the outstanding count never exceeds 2; rvalids arrive in order.
- Grant stall:
  - Setup: GNT_STALL=3; req asserted at cycle 0.
  - gnt first at cycle 3. Dropping req at cycle 2 and reasserting at cycle 4 gives gnt at cycle 7.
- Reset mid-operation:
  - Assert RST 1 cycle after a read is granted with RVALID_LAT=2.
  - No rvalid is seen, outputs are 0 the next cycle, and the array keeps earlier write data.
